// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic {IDLE, BURST} arb_state_e;

  function automatic int wrap_inc(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle; master = arbiter side.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ*FIFO_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [IW-1:0]                 gnt_id;
  logic                          busy;

  modport master (
    input  req, last, data, fifo_full,
    output ready, fifo_wr_en, fifo_data_in, gnt_id, busy
  );

  modport slave (
    output req, last, data, fifo_full,
    input  ready, fifo_wr_en, fifo_data_in, gnt_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotating-priority encoder: first set req bit at or after rr_ptr, wrapping.
module fifo_wr_arbiter_rr_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among producers.
//  state | meaning
//  IDLE  | no owner; grant the next requester combinationally unless resting
//  BURST | gnt_id owns the port until last, MAX_BURST beats, or req drop
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input logic           clk,
  input logic           rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 4;

  arb_state_e            state, state_nxt;
  logic [IW-1:0]         gnt_q, gnt_nxt, rr_ptr, rr_nxt, owner, pick_idx;
  logic [CW-1:0]         beat_cnt, cnt_nxt, cnt_inc;
  logic                  rest, rest_nxt;
  logic                  pick_valid, grant_valid, beat, grant_end;
  logic [NUM_REQ-1:0]    ready;
  logic [FIFO_WIDTH-1:0] data_arr [NUM_REQ];

  fifo_wr_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      data_arr[i] = bus.data[i*FIFO_WIDTH +: FIFO_WIDTH];
  end

  // A grant that ends on a beat leaves one rest cycle before the next pick.
  always_comb begin
    owner       = (state == IDLE) ? pick_idx : gnt_q;
    grant_valid = (state == BURST) || (pick_valid && !rest);
    ready       = '0;
    if (!rst && grant_valid && bus.req[owner] && !bus.fifo_full)
      ready[owner] = 1'b1;
    beat      = |ready;
    cnt_inc   = beat_cnt + CW'(beat);
    grant_end = (beat && (bus.last[owner] || cnt_inc == CW'(MAX_BURST))) ||
                (state == BURST && !bus.req[owner] && !bus.fifo_full);

    state_nxt = state;
    gnt_nxt   = gnt_q;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    rest_nxt  = 1'b0;
    if (grant_valid) begin
      gnt_nxt = owner;
      if (grant_end) begin
        state_nxt = IDLE;
        rr_nxt    = IW'(wrap_inc(int'(owner), NUM_REQ));
        cnt_nxt   = '0;
        rest_nxt  = beat;
      end else begin
        state_nxt = BURST;
        cnt_nxt   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      rest     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
      rest     <= rest_nxt;
    end
  end

  assign bus.ready        = ready;
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_data_in = beat ? data_arr[owner] : '0;
  assign bus.gnt_id       = gnt_q;
  assign bus.busy         = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand sequences, random vs model.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int MAXB = 4;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  ready;
    logic        wr;
    logic [15:0] data;
    logic [1:0]  gnt;
    logic        busy;
  } vec_t;

  vec_t tbl [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(logic r, logic [3:0] rq, logic [3:0] lt, logic f);
    rst           = r;
    bus.req       = rq;
    bus.last      = lt;
    bus.fifo_full = f;
  endtask

  // Sample mid-cycle, then move to just after the next rising edge.
  task automatic check(string nm, logic [3:0] er, logic ew, logic [15:0] ed,
                       logic [1:0] eg, logic eb);
    @(negedge clk);
    cmp({nm, ".ready"}, 32'(bus.ready), 32'(er));
    cmp({nm, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(ew));
    cmp({nm, ".data"},  32'(bus.fifo_data_in), 32'(ed));
    cmp({nm, ".gnt"},   32'(bus.gnt_id), 32'(eg));
    cmp({nm, ".busy"},  32'(bus.busy), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic r, logic [3:0] rq, logic [3:0] lt, logic f,
                     logic [3:0] er, logic ew, logic [15:0] ed, logic [1:0] eg, logic eb);
    tbl.push_back('{r, rq, lt, f, er, ew, ed, eg, eb});
  endtask

  int          m_owner, m_ptr, m_beats, m_gnt, found, cur;
  bit          m_rest, m_beat, m_end;
  logic [3:0]  exp_ready;
  logic [15:0] exp_data;
  int          exp_writes, act_writes;

  initial begin
    apply(1'b1, 4'h0, 4'h0, 1'b0);
    bus.data = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
    #1;

    // reset, reset mid-burst, regrant after release
    add(1, 4'h0, 4'h0, 0, 4'h0, 0, 16'h0,  0, 0);
    add(0, 4'h1, 4'h0, 0, 4'h1, 1, 16'hA0, 0, 0);
    add(0, 4'h1, 4'h0, 0, 4'h1, 1, 16'hA0, 0, 1);
    add(1, 4'h1, 4'h0, 0, 4'h0, 0, 16'h0,  0, 0);
    add(0, 4'h4, 4'h0, 0, 4'h4, 1, 16'hA2, 0, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 0, 16'h0,  2, 1);
    // all request with last: strict rotation, one rest cycle between writes
    add(1, 4'h0, 4'h0, 0, 4'h0, 0, 16'h0,  0, 0);
    add(0, 4'hF, 4'hF, 0, 4'h1, 1, 16'hA0, 0, 0);
    add(0, 4'hF, 4'hF, 0, 4'h0, 0, 16'h0,  0, 0);
    add(0, 4'hF, 4'hF, 0, 4'h2, 1, 16'hA1, 0, 0);
    add(0, 4'hF, 4'hF, 0, 4'h0, 0, 16'h0,  1, 0);
    add(0, 4'hF, 4'hF, 0, 4'h4, 1, 16'hA2, 1, 0);
    add(0, 4'hF, 4'hF, 0, 4'h0, 0, 16'h0,  2, 0);
    add(0, 4'hF, 4'hF, 0, 4'h8, 1, 16'hA3, 2, 0);
    add(0, 4'hF, 4'hF, 0, 4'h0, 0, 16'h0,  3, 0);
    add(0, 4'hF, 4'hF, 0, 4'h1, 1, 16'hA0, 3, 0);
    // single requester with last: write every second cycle
    add(0, 4'h2, 4'h2, 0, 4'h0, 0, 16'h0,  0, 0);
    add(0, 4'h2, 4'h2, 0, 4'h2, 1, 16'hA1, 0, 0);
    add(0, 4'h2, 4'h2, 0, 4'h0, 0, 16'h0,  1, 0);
    add(0, 4'h2, 4'h2, 0, 4'h2, 1, 16'hA1, 1, 0);
    add(0, 4'h2, 4'h2, 0, 4'h0, 0, 16'h0,  1, 0);
    add(0, 4'h2, 4'h2, 0, 4'h2, 1, 16'hA1, 1, 0);
    add(0, 4'h0, 4'h0, 0, 4'h0, 0, 16'h0,  1, 0);
    add(0, 4'h0, 4'hF, 0, 4'h0, 0, 16'h0,  1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].full);
      check($sformatf("vec%0d", i), tbl[i].ready, tbl[i].wr, tbl[i].data,
            tbl[i].gnt, tbl[i].busy);
    end

    // MAX_BURST forced rotation with req1 pending
    apply(1, 4'h0, 4'h0, 0); check("t3_rst", 4'h0, 0, 16'h0, 0, 0);
    apply(0, 4'h3, 4'h0, 0);
    check("t3_b1",  4'h1, 1, 16'hA0, 0, 0);
    check("t3_b2",  4'h1, 1, 16'hA0, 0, 1);
    check("t3_b3",  4'h1, 1, 16'hA0, 0, 1);
    check("t3_b4",  4'h1, 1, 16'hA0, 0, 1);
    check("t3_rest", 4'h0, 0, 16'h0, 0, 0);
    check("t3_r1",  4'h2, 1, 16'hA1, 0, 0);
    check("t3_r1b", 4'h2, 1, 16'hA1, 1, 1);
    apply(0, 4'h0, 4'h0, 0);
    check("t3_drop", 4'h0, 0, 16'h0, 1, 1);

    // fifo_full mid-burst at beat_cnt=2, req drop while full is ignored
    apply(1, 4'h0, 4'h0, 0); check("t4_rst", 4'h0, 0, 16'h0, 0, 0);
    apply(0, 4'h3, 4'h0, 0);
    check("t4_b1", 4'h1, 1, 16'hA0, 0, 0);
    check("t4_b2", 4'h1, 1, 16'hA0, 0, 1);
    apply(0, 4'h3, 4'h0, 1); check("t4_full1", 4'h0, 0, 16'h0, 0, 1);
    apply(0, 4'h2, 4'h0, 1); check("t4_full2", 4'h0, 0, 16'h0, 0, 1);
    apply(0, 4'h3, 4'h0, 1); check("t4_full3", 4'h0, 0, 16'h0, 0, 1);
    apply(0, 4'h3, 4'h0, 0);
    check("t4_b3",   4'h1, 1, 16'hA0, 0, 1);
    check("t4_b4",   4'h1, 1, 16'hA0, 0, 1);
    check("t4_rest", 4'h0, 0, 16'h0, 0, 0);
    check("t4_r1",   4'h2, 1, 16'hA1, 0, 0);

    // random traffic against a behavioural model
    apply(1, 4'h0, 4'h0, 0); check("t6_rst", 4'h0, 0, 16'h0, 0, 0);
    m_owner = -1; m_ptr = 0; m_beats = 0; m_gnt = 0; m_rest = 0;
    exp_writes = 0; act_writes = 0;
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.req[i]  = ($urandom_range(0, 3) != 0);
        bus.last[i] = ($urandom_range(0, 5) == 0);
      end
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      bus.data      = {$urandom(), $urandom()};
      @(negedge clk);

      cur = m_owner;
      if (m_owner < 0 && !m_rest) begin
        found = -1;
        for (int k = 0; k < N; k++)
          if (found < 0 && bus.req[(m_ptr + k) % N]) found = (m_ptr + k) % N;
        cur = found;
      end
      exp_ready = '0;
      exp_data  = '0;
      if (cur >= 0 && bus.req[cur] && !bus.fifo_full) begin
        exp_ready[cur] = 1'b1;
        exp_data = bus.data[cur*W +: W];
      end
      m_beat = (exp_ready != 0);

      cmp($sformatf("rnd%0d.ready", c), 32'(bus.ready), 32'(exp_ready));
      cmp($sformatf("rnd%0d.wr_en", c), 32'(bus.fifo_wr_en), 32'(m_beat));
      cmp($sformatf("rnd%0d.data", c), 32'(bus.fifo_data_in), 32'(exp_data));
      cmp($sformatf("rnd%0d.gnt", c), 32'(bus.gnt_id), 32'(m_gnt));
      cmp($sformatf("rnd%0d.busy", c), 32'(bus.busy), 32'(m_owner >= 0));
      cmp($sformatf("rnd%0d.onehot", c), 32'($countones(bus.ready) <= 1), 32'(1));
      cmp($sformatf("rnd%0d.wr_full", c), 32'(bus.fifo_wr_en && bus.fifo_full), 32'(0));
      if (m_beat) exp_writes++;
      if (bus.fifo_wr_en === 1'b1) act_writes++;

      if (cur >= 0) begin
        m_gnt = cur;
        if (m_beat) m_beats++;
        m_end = (m_beat && (bus.last[cur] || m_beats == MAXB)) ||
                (m_owner >= 0 && !bus.req[cur] && !bus.fifo_full);
        if (m_end) begin
          m_ptr   = (cur + 1) % N;
          m_owner = -1;
          m_beats = 0;
          m_rest  = m_beat;
        end else begin
          m_owner = cur;
          m_rest  = 0;
        end
      end else begin
        m_rest = 0;
      end
      @(posedge clk);
      #1;
    end
    cmp("rnd.total_writes", 32'(act_writes), 32'(exp_writes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
